// File: rtl/risc16_pkg.sv
// Shared encodings for the RiSC-16 multi-cycle controller: opcodes, ALU
// function codes, PC/register-write source selects and FSM states.
package risc16_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    localparam logic [1:0] FUNC_ADD   = 2'b00;
    localparam logic [1:0] FUNC_NAND  = 2'b01;
    localparam logic [1:0] FUNC_PASS1 = 2'b10;
    localparam logic [1:0] FUNC_EQL   = 2'b11;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_ALU    = 2'b10;

    localparam logic [1:0] WSEL_ALU = 2'b00;
    localparam logic [1:0] WSEL_MEM = 2'b01;
    localparam logic [1:0] WSEL_PC  = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

endpackage

// File: rtl/risc16_ctrl_decode.sv
// Static per-opcode datapath settings; don't-care mux selects resolve to 0.
module risc16_ctrl_decode
    import risc16_pkg::*;
(
    input  logic [2:0] op,
    output logic       mux_alu1,
    output logic       mux_alu2,
    output logic [1:0] func_alu,
    output logic       rf_rsel2,
    output logic [1:0] rf_wsel
);

    always_comb begin
        mux_alu1 = 1'b0;
        mux_alu2 = 1'b0;
        func_alu = FUNC_ADD;
        rf_rsel2 = 1'b0;
        rf_wsel  = WSEL_ALU;
        unique case (op)
            OP_ADD:  ;
            OP_ADDI: mux_alu2 = 1'b1;
            OP_NAND: func_alu = FUNC_NAND;
            OP_LUI: begin
                mux_alu1 = 1'b1;
                func_alu = FUNC_PASS1;
            end
            OP_SW: begin
                mux_alu2 = 1'b1;
                rf_rsel2 = 1'b1;
            end
            OP_LW: begin
                mux_alu2 = 1'b1;
                rf_wsel  = WSEL_MEM;
            end
            OP_BEQ: begin
                func_alu = FUNC_EQL;
                rf_rsel2 = 1'b1;
            end
            OP_JALR: begin
                func_alu = FUNC_PASS1;
                rf_wsel  = WSEL_PC;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/risc16_control.sv
// Multi-cycle RiSC-16 control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT, with
// outputs decoded combinationally from the state and the latched opcode.
module risc16_control
    import risc16_pkg::*;
#(
    parameter bit HALT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        EQ,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        MUX_alu1,
    output logic        MUX_alu2,
    output logic [1:0]  FUNC_alu,
    output logic        rf_rsel2,
    output logic        rf_we,
    output logic [1:0]  rf_wsel,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        halted,
    output logic        retire
);

    state_t     state;
    logic [2:0] op_q;
    logic [2:0] ra_q;
    logic       halt_q;

    logic       dec_alu1;
    logic       dec_alu2;
    logic [1:0] dec_func;
    logic       dec_rsel2;
    logic [1:0] dec_wsel;

    // rB/rC fields are consumed by the register file directly, not here.
    logic unused_rb;
    assign unused_rb = ^instr[9:7];

    risc16_ctrl_decode u_decode (
        .op       (op_q),
        .mux_alu1 (dec_alu1),
        .mux_alu2 (dec_alu2),
        .func_alu (dec_func),
        .rf_rsel2 (dec_rsel2),
        .rf_wsel  (dec_wsel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_FETCH;
            op_q   <= OP_ADD;
            halt_q <= 1'b0;
        end else begin
            unique case (state)
                ST_FETCH:  if (mem_ready) state <= ST_DECODE;
                ST_DECODE: begin
                    op_q   <= instr[15:13];
                    halt_q <= HALT_EN && (instr[15:13] == OP_JALR) && (instr[6:0] != 7'd0);
                    state  <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (op_q == OP_BEQ)                        state <= ST_FETCH;
                    else if (op_q == OP_LW || op_q == OP_SW)   state <= ST_MEM;
                    else if (halt_q)                           state <= ST_HALT;
                    else                                       state <= ST_WB;
                end
                ST_MEM: begin
                    if (mem_ready) state <= (op_q == OP_SW) ? ST_FETCH : ST_WB;
                end
                ST_WB:   state <= ST_FETCH;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

    // Destination register index is data, so it is captured without reset.
    always_ff @(posedge clk) begin
        if (state == ST_DECODE) ra_q <= instr[12:10];
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        MUX_alu1     = 1'b0;
        MUX_alu2     = 1'b0;
        FUNC_alu     = FUNC_ADD;
        rf_rsel2     = 1'b0;
        rf_we        = 1'b0;
        rf_wsel      = WSEL_ALU;
        pc_we        = 1'b0;
        pc_src       = PC_INC;
        halted       = 1'b0;
        retire       = 1'b0;
        if (!rst) begin
            unique case (state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we = 1'b1;
                        pc_we = 1'b1;
                    end
                end
                ST_DECODE: ;
                ST_EXEC: begin
                    MUX_alu1 = dec_alu1;
                    MUX_alu2 = dec_alu2;
                    FUNC_alu = dec_func;
                    rf_rsel2 = dec_rsel2;
                    if (op_q == OP_BEQ) begin
                        pc_we  = EQ;
                        pc_src = PC_BRANCH;
                        retire = 1'b1;
                    end
                end
                ST_MEM: begin
                    MUX_alu1     = dec_alu1;
                    MUX_alu2     = dec_alu2;
                    FUNC_alu     = dec_func;
                    rf_rsel2     = dec_rsel2;
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (op_q == OP_SW);
                    retire       = mem_ready && (op_q == OP_SW);
                end
                ST_WB: begin
                    MUX_alu1 = dec_alu1;
                    MUX_alu2 = dec_alu2;
                    FUNC_alu = dec_func;
                    rf_rsel2 = dec_rsel2;
                    rf_we    = (ra_q != 3'd0);
                    rf_wsel  = dec_wsel;
                    retire   = 1'b1;
                    if (op_q == OP_JALR) begin
                        pc_we  = 1'b1;
                        pc_src = PC_ALU;
                    end
                end
                ST_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_risc16_control.sv
// Bench for risc16_control: per-instruction vector table expanded into
// per-cycle expectations that flow through a scoreboard queue.
module tb_risc16_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        EQ;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_we;
    logic        MUX_alu1, MUX_alu2;
    logic [1:0]  FUNC_alu;
    logic        rf_rsel2, rf_we;
    logic [1:0]  rf_wsel;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        halted, retire;

    always #5 clk = ~clk;

    risc16_control #(.HALT_EN(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .EQ           (EQ),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .MUX_alu1     (MUX_alu1),
        .MUX_alu2     (MUX_alu2),
        .FUNC_alu     (FUNC_alu),
        .rf_rsel2     (rf_rsel2),
        .rf_we        (rf_we),
        .rf_wsel      (rf_wsel),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .halted       (halted),
        .retire       (retire)
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       alu1;
        logic       alu2;
        logic [1:0] func;
        logic       rsel2;
        logic       rf_we;
        logic [1:0] wsel;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       halted;
        logic       retire;
    } ctl_t;

    typedef struct {
        logic [15:0] instr;
        logic        eq;
        int          fw;
        int          mw;
        logic        a1;
        logic        a2;
        logic        a2x;
        logic [1:0]  func;
        logic        rsel2;
        logic [1:0]  wsel;
        int          lat;
    } vec_t;

    ctl_t exp_q[$];
    ctl_t msk_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[14];

    function automatic vec_t mk(input logic [15:0] i, input logic eq, input int fw, input int mw,
                                input logic a1, input logic a2, input logic a2x, input logic [1:0] func,
                                input logic rsel2, input logic [1:0] wsel, input int lat);
        vec_t v;
        v.instr = i; v.eq = eq; v.fw = fw; v.mw = mw;
        v.a1 = a1; v.a2 = a2; v.a2x = a2x; v.func = func;
        v.rsel2 = rsel2; v.wsel = wsel; v.lat = lat;
        return v;
    endfunction

    function automatic ctl_t sample();
        ctl_t a;
        a.mem_req = mem_req; a.mem_we = mem_we; a.mem_addr_sel = mem_addr_sel; a.ir_we = ir_we;
        a.alu1 = MUX_alu1; a.alu2 = MUX_alu2; a.func = FUNC_alu; a.rsel2 = rf_rsel2;
        a.rf_we = rf_we; a.wsel = rf_wsel; a.pc_we = pc_we; a.pc_src = pc_src;
        a.halted = halted; a.retire = retire;
        return a;
    endfunction

    // Drive one cycle, queue its expectation, check it on the falling edge.
    task automatic step(input int idx, input string nm, input logic [15:0] i_instr, input logic i_eq,
                        input logic i_rdy, input logic i_rst, input ctl_t e, input ctl_t m,
                        output logic ret);
        logic [17:0] got, want, msk;
        instr = i_instr; EQ = i_eq; mem_ready = i_rdy; rst = i_rst;
        exp_q.push_back(e);
        msk_q.push_back(m);
        @(negedge clk);
        got  = sample();
        want = exp_q.pop_front();
        msk  = msk_q.pop_front();
        ret  = retire;
        n_vec++;
        if ((got & msk) !== (want & msk)) begin
            n_bad++;
            $display("FAIL v%0d %s: outputs got %h, required %h (care mask %h)", idx, nm, got, want, msk);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic ctl_t alu_fields(input vec_t v);
        ctl_t e = '0;
        e.alu1 = v.a1; e.alu2 = v.a2; e.func = v.func; e.rsel2 = v.rsel2;
        return e;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        ctl_t full = '1;
        ctl_t e, m;
        logic [2:0] op = v.instr[15:13];
        logic r;
        int cyc = 0;
        int got_lat = 0;
        m = full;
        if (v.a2x) m.alu2 = 1'b0;
        for (int k = 0; k < v.fw; k++) begin
            e = '0; e.mem_req = 1'b1;
            step(idx, "fetch_wait", 16'($urandom), 1'($urandom), 1'b0, 1'b0, e, full, r);
            cyc++;
        end
        e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; e.pc_src = 2'b00;
        step(idx, "fetch", 16'($urandom), 1'($urandom), 1'b1, 1'b0, e, full, r);
        cyc++;
        e = '0;
        step(idx, "decode", v.instr, 1'($urandom), 1'b1, 1'b0, e, full, r);
        cyc++;
        e = alu_fields(v);
        if (op == 3'b110) begin
            e.pc_we = v.eq; e.pc_src = 2'b01; e.retire = 1'b1;
        end
        step(idx, "exec", 16'($urandom), (op == 3'b110) ? v.eq : 1'($urandom), 1'b1, 1'b0, e, m, r);
        cyc++;
        if (r && got_lat == 0) got_lat = cyc;
        if (op == 3'b100 || op == 3'b101) begin
            for (int k = 0; k <= v.mw; k++) begin
                e = alu_fields(v);
                e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = (op == 3'b100);
                e.retire = (op == 3'b100) && (k == v.mw);
                step(idx, "mem", 16'($urandom), 1'($urandom), (k == v.mw), 1'b0, e, m, r);
                cyc++;
                if (r && got_lat == 0) got_lat = cyc;
            end
        end
        if (op != 3'b110 && op != 3'b100) begin
            e = alu_fields(v);
            e.rf_we = (v.instr[12:10] != 3'd0); e.wsel = v.wsel; e.retire = 1'b1;
            if (op == 3'b111) begin
                e.pc_we = 1'b1; e.pc_src = 2'b10;
            end
            step(idx, "wb", 16'($urandom), 1'($urandom), 1'b1, 1'b0, e, m, r);
            cyc++;
            if (r && got_lat == 0) got_lat = cyc;
        end
        n_vec++;
        if (got_lat != v.lat) begin
            n_bad++;
            $display("FAIL v%0d latency: retire at cycle %0d, required %0d", idx, got_lat, v.lat);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_t z = '0;
        ctl_t full = '1;
        ctl_t e, m;
        logic r;

        //                 instr     eq  fw mw a1 a2 a2x func   rs wsel   lat
        vecs[0]  = mk(16'h0503, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 4); // ADD r1
        vecs[1]  = mk(16'h2503, 0, 0, 0, 0, 1, 0, 2'b00, 0, 2'b00, 4); // ADDI
        vecs[2]  = mk(16'h4503, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 4); // NAND
        vecs[3]  = mk(16'h6000, 0, 0, 0, 1, 0, 1, 2'b10, 0, 2'b00, 4); // LUI r0
        vecs[4]  = mk(16'h6480, 0, 0, 0, 1, 0, 1, 2'b10, 0, 2'b00, 4); // LUI r1
        vecs[5]  = mk(16'h8503, 0, 0, 0, 0, 1, 0, 2'b00, 1, 2'b00, 4); // SW
        vecs[6]  = mk(16'h8503, 0, 0, 1, 0, 1, 0, 2'b00, 1, 2'b00, 5); // SW, 1 wait
        vecs[7]  = mk(16'hA503, 0, 0, 2, 0, 1, 0, 2'b00, 0, 2'b01, 7); // LW, 2 waits
        vecs[8]  = mk(16'hA503, 0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b01, 6); // LW, fetch wait
        vecs[9]  = mk(16'hC505, 1, 0, 0, 0, 0, 0, 2'b11, 1, 2'b00, 3); // BEQ taken
        vecs[10] = mk(16'hC505, 0, 0, 0, 0, 0, 0, 2'b11, 1, 2'b00, 3); // BEQ not taken
        vecs[11] = mk(16'hE500, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b10, 4); // JALR r1
        vecs[12] = mk(16'h0103, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 4); // ADD r0
        vecs[13] = mk(16'hE100, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b10, 4); // JALR r0

        rst = 1'b1; instr = 16'h0; EQ = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        step(-1, "reset", 16'hA503, 1'b1, 1'b1, 1'b1, z, full, r);
        step(-1, "reset", 16'hFFFF, 1'b1, 1'b1, 1'b1, z, full, r);

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // JALR with nonzero imm7 halts until reset.
        e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
        step(100, "halt_fetch", 16'h0, 1'b0, 1'b1, 1'b0, e, full, r);
        step(100, "halt_decode", 16'hE501, 1'b0, 1'b1, 1'b0, z, full, r);
        e = '0; e.func = 2'b10; m = full; m.alu2 = 1'b0;
        step(100, "halt_exec", 16'($urandom), 1'b1, 1'b1, 1'b0, e, m, r);
        e = '0; e.halted = 1'b1;
        for (int k = 0; k < 20; k++)
            step(100, "halted", 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, e, full, r);
        step(100, "halt_rst", 16'h0, 1'b0, 1'b1, 1'b1, z, full, r);
        e = '0; e.mem_req = 1'b1;
        step(100, "post_halt_fetch", 16'h0, 1'b0, 1'b0, 1'b0, e, full, r);
        run_vec(101, vecs[0]);

        // Reset in the middle of an SW memory wait drops the store.
        e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
        step(102, "sw_fetch", 16'h0, 1'b0, 1'b1, 1'b0, e, full, r);
        step(102, "sw_decode", 16'h8503, 1'b0, 1'b1, 1'b0, z, full, r);
        e = alu_fields(vecs[5]);
        step(102, "sw_exec", 16'h0, 1'b0, 1'b1, 1'b0, e, full, r);
        e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = 1'b1;
        step(102, "sw_mem_wait", 16'h0, 1'b0, 1'b0, 1'b0, e, full, r);
        step(102, "sw_mem_rst", 16'h0, 1'b0, 1'b1, 1'b1, z, full, r);
        e = '0; e.mem_req = 1'b1;
        step(102, "sw_after_rst", 16'h0, 1'b0, 1'b0, 1'b0, e, full, r);
        run_vec(103, vecs[2]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/risc16_control.md
Name: risc16_control

Overview:
- Multi-cycle control FSM for the RiSC-16 datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the ALU control inputs (MUX_alu1, MUX_alu2, FUNC_alu) and consumes the ALU EQ flag.
- Also drives the register-file, PC, IR and memory-request controls. Sits between the IR and every datapath control point.

Parameters:
- HALT_EN, 1, when 1 a JALR with a nonzero imm7 enters HALT; when 0 it executes as a plain JALR.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- instr  in  16  IR contents: op=[15:13], rA=[12:10], rB=[9:7], imm7=[6:0], rC=[2:0]
- EQ  in  1  ALU equality flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request (fetch or data)
- mem_we  out  1  data write (SW only); only valid while mem_req=1
- mem_addr_sel  out  1  0=PC (fetch), 1=alu_out (data)
- ir_we  out  1  load IR from memory data
- MUX_alu1  out  1  0=rf port1 (rB), 1=imm10<<6
- MUX_alu2  out  1  0=rf port2, 1=sign-extended imm7
- FUNC_alu  out  2  00 ADD, 01 NAND, 10 PASS1, 11 EQL
- rf_rsel2  out  1  rf port2 address: 0=rC, 1=rA
- rf_we  out  1  register write enable, dest rA
- rf_wsel  out  2  00 alu_out, 01 mem data, 10 PC
- pc_we  out  1  PC write enable
- pc_src  out  2  00 PC+1, 01 PC+se_imm7, 10 alu_out
- halted  out  1  high in HALT
- retire  out  1  one-cycle pulse on each instruction's final cycle

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Outputs are combinational from the state register and op_q/rA_q, latched in DECODE. While rst=1, all outputs are 0. On reset the state becomes FETCH and op_q=0.
- FETCH:
  - mem_req=1, mem_addr_sel=0.
  - Holds until mem_ready.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=00, then go to DECODE.
- DECODE: latch op_q and rA_q; go to EXEC.
- EXEC: ALU settings per op:
  - ADD: 0/0/00.
  - ADDI: 0/1/00.
  - NAND: 0/0/01.
  - LUI: 1/x/10.
  - LW and SW: 0/1/00.
  - BEQ: 0/0/11.
  - JALR: 0/x/10.
  - rf_rsel2=1 for SW and BEQ, 0 otherwise.
- EXEC exits:
  - BEQ: pc_we=EQ, pc_src=01 (PC is already incremented), retire=1, then FETCH.
  - LW and SW: go to MEM.
  - JALR with HALT_EN and imm7!=0: go to HALT.
  - All other ops: go to WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=(op=SW).
  - ALU controls are held at their EXEC values.
  - Holds until mem_ready.
  - SW: retire=1 and go to FETCH. LW: go to WB.
- WB:
  - rf_we=1 unless rA_q==0 (r0 writes are suppressed here).
  - rf_wsel: 01 for LW, 10 for JALR, 00 otherwise.
  - JALR also asserts pc_we=1, pc_src=10, with ALU held at PASS1. rA receives the old PC+1 and the PC receives rB in the same edge.
  - retire=1, then FETCH.
- HALT: halted=1, all other outputs 0. Stays until rst.
- Latency with zero-wait memory:
  - BEQ: 3 cycles.
  - ADD, ADDI, NAND, LUI, SW, JALR: 4 cycles.
  - LW: 5 cycles.
  - Each mem_ready-low cycle adds 1.
- Boundary conditions:
  - rst mid-MEM: the pending request is dropped and the FSM returns to FETCH with no write.
  - A mem_ready arriving outside FETCH or MEM is ignored.
  - EQ is sampled only in EXEC for BEQ.

Decomposition:
- Package risc16_pkg holds:
  - opcode constants OP_ADD..OP_JALR (000..111).
  - FUNC_alu codes.
  - pc_src and rf_wsel codes.
  - state enum.
- Sub-module risc16_ctrl_decode: combinational op → {MUX_alu1, MUX_alu2, FUNC_alu, rf_rsel2, rf_wsel}.

Test Plan:
- ADD r1,r2,r3 (0x0503), mem_ready=1 → states FETCH,DECODE,EXEC,WB; in EXEC FUNC_alu=00, muxes 0/0, rf_rsel2=0; in WB rf_we=1, rf_wsel=00; retire on cycle 4.
- BEQ 0xC505: EQ=1 in EXEC → pc_we=1, pc_src=01, retire on cycle 3. With EQ=0 → pc_we=0 in EXEC.
- LW 0xA503, mem_ready low for 2 MEM cycles → mem_req=1 and mem_addr_sel=1 held for 3 cycles; WB has rf_wsel=01; total 7 cycles.
- JALR 0xE500 → WB has rf_we=1, rf_wsel=10, pc_we=1, pc_src=10. 0xE501 → HALT, halted=1 held for 20 cycles; rst → FETCH, halted=0.
- ADD r0 (0x0103) → rf_we=0 throughout. LUI 0x6000 → MUX_alu1=1, FUNC_alu=10.
- rst asserted mid-MEM of SW → mem_we=0 next cycle, next state FETCH, no retire.
